// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Holds the fetch PC and issues one word request at a time to a
// variable-latency instruction memory (req held until ack). Returned words
// are buffered with their PCs in a DEPTH-entry FIFO that decode drains over
// valid/ready. A redirect flushes the FIFO and restarts fetch at the new
// target; a response still in flight at that point is dropped on arrival.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_req/addr       outstanding request and its word address
//   imem_ack/rdata      single-cycle response strobe and instruction
//   redirect_valid/pc   restart fetch at redirect_pc (low two bits ignored)
//   out_valid/ready     decode handshake on the FIFO head
//   out_pc/pc_plus4     head PC and head PC + 4 (wraps)
//   out_instr           head instruction
//   count               occupied FIFO entries
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_ack,
    input  logic [DATA_W-1:0]       imem_rdata,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W-1:0]       out_pc,
    output logic [ADDR_W-1:0]       out_pc_plus4,
    output logic [DATA_W-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               drop;

    logic               ack_hit;
    logic               push;
    logic               pop;
    logic               busy;
    logic               issue;
    logic [CNT_W-1:0]   count_next;

    // Word alignment is forced on redirect targets, so the low bits are dead.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign ack_hit    = imem_req & imem_ack;   // acks with no request are ignored
    assign push       = ack_hit & ~drop;
    assign pop        = out_valid & out_ready;
    assign busy       = imem_req & ~imem_ack;  // request still waiting after this cycle
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Only issue when the response is guaranteed a free slot, counting this
    // cycle's push and pop; a push therefore never meets a full FIFO.
    assign issue = ~busy & ~redirect_valid & (count_next < CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            drop      <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else if (redirect_valid) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            if (busy) begin
                // Keep the bus request alive; its data is thrown away.
                drop <= 1'b1;
            end else begin
                imem_req <= 1'b0;
                drop     <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_q[tail] <= '{pc: imem_addr, instr: imem_rdata};
                tail         <= tail + PTR_W'(1);
            end
            if (pop) head <= head + PTR_W'(1);
            count <= count_next;
            if (ack_hit) drop <= 1'b0;
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + ADDR_W'(4);
            end else if (ack_hit) begin
                imem_req <= 1'b0;
            end
        end
    end

    assign out_valid    = (count != '0);
    assign out_pc       = fifo_q[head].pc;
    assign out_instr    = fifo_q[head].instr;
    assign out_pc_plus4 = out_pc + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        imem_req, imem_ack, redirect_valid, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_pc, out_pc_plus4, out_instr;
    logic [2:0]  count;

    // second DUT for the reset-PC wrap case
    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, pc2, pc42, instr2;
    logic [2:0]  count2;

    // memory model controls
    logic        mem_en, man_ack, auto_ack;
    int          acks_left;

    assign imem_ack   = mem_en ? auto_ack : man_ack;
    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;
    assign rdata2     = addr2 ^ 32'hC0DE_0000;

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .count(count)
    );

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(valid2), .out_ready(1'b1), .out_pc(pc2),
        .out_pc_plus4(pc42), .out_instr(instr2), .count(count2)
    );

    typedef struct { logic [31:0] pc; logic [31:0] pc4; logic [31:0] instr; } exp_t;
    exp_t q[$];
    exp_t q2[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] instr);
        exp_t e;
        e.pc = pc; e.pc4 = pc4; e.instr = instr;
        q.push_back(e);
    endtask

    // Memory responder: acks a request in its second cycle or later, while
    // acks_left permits.
    initial begin
        int  age;
        logic r_prev, a_prev;
        age = 0; r_prev = 1'b0; a_prev = 1'b0; auto_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req) age = (!r_prev || a_prev) ? 0 : age + 1;
            auto_ack = !reset && imem_req && (age >= 1) && (acks_left > 0);
            #4;
            r_prev = imem_req;
            a_prev = imem_ack;
            if (mem_en && imem_ack && imem_req && !reset) acks_left--;
        end
    end

    // Responder for the second DUT: exactly three acks, every other cycle.
    int   acks2 = 0;
    initial begin
        logic hold2;
        hold2 = 1'b0; ack2 = 1'b0;
        forever begin
            @(negedge clk);
            ack2  = (acks2 < 3) && req2 && hold2 && !ack2;
            hold2 = req2;
            if (ack2) acks2++;
        end
    end

    // Scoreboard monitors: compare every accepted head against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #4;
            if (!reset && !redirect_valid && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pop: got pc %h with no entry expected", out_pc);
                end else begin
                    e = q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_pc_plus4", out_pc_plus4, e.pc4);
                    chk("out_instr", out_instr, e.instr);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #4;
            if (!reset && valid2) begin
                if (q2.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pop2: got pc %h with no entry expected", pc2);
                end else begin
                    e = q2.pop_front();
                    chk("wrap_out_pc", pc2, e.pc);
                    chk("wrap_out_pc_plus4", pc42, e.pc4);
                    chk("wrap_out_instr", instr2, e.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1'b1; mem_en = 1'b1; man_ack = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; acks_left = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_q_empty(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin ok = 1'b1; break; end
        end
        chk(name, ok, 1'b1);
    endtask

    initial begin
        logic       ok;
        logic [2:0] max_cnt;
        exp_t       e;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        man_ack = 1'b0; mem_en = 1'b1; acks_left = 0;
        e.pc = 32'hFFFF_FFF8; e.pc4 = 32'hFFFF_FFFC; e.instr = 32'h3F21_FFF8; q2.push_back(e);
        e.pc = 32'hFFFF_FFFC; e.pc4 = 32'h0000_0000; e.instr = 32'h3F21_FFFC; q2.push_back(e);
        e.pc = 32'h0000_0000; e.pc4 = 32'h0000_0004; e.instr = 32'hC0DE_0000; q2.push_back(e);
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_pc_plus4", out_pc_plus4, 32'h4);
        chk("rst_out_instr", out_instr, 32'h0);

        // streaming with 1-cycle ack, decode always ready
        push_exp(32'h0, 32'h4, 32'hC0DE_0000);
        push_exp(32'h4, 32'h8, 32'hC0DE_0004);
        push_exp(32'h8, 32'hC, 32'hC0DE_0008);
        push_exp(32'hC, 32'h10, 32'hC0DE_000C);
        acks_left = 4; out_ready = 1'b1; reset = 1'b0;
        @(negedge clk);
        chk("t1_first_req", imem_req, 1);
        chk("t1_first_addr", imem_addr, 32'h0);
        max_cnt = count; ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (count > max_cnt) max_cnt = count;
            if (q.size() == 0) begin ok = 1'b1; break; end
        end
        chk("t1_drain", ok, 1);
        chk("t1_max_count", max_cnt, 1);
        chk("t1_next_req", imem_req, 1);
        chk("t1_next_addr", imem_addr, 32'h10);

        // back-pressure fills exactly DEPTH entries
        do_reset();
        push_exp(32'h0, 32'h4, 32'hC0DE_0000);
        push_exp(32'h4, 32'h8, 32'hC0DE_0004);
        push_exp(32'h8, 32'hC, 32'hC0DE_0008);
        push_exp(32'hC, 32'h10, 32'hC0DE_000C);
        acks_left = 4; reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count == 3'd4) begin ok = 1'b1; break; end
        end
        chk("t2_fill", ok, 1);
        repeat (2) @(negedge clk);
        chk("t2_full_count", count, 4);
        chk("t2_full_req", imem_req, 0);
        chk("t2_full_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t2_pop_count", count, 3);
        chk("t2_pop_req", imem_req, 1);
        chk("t2_pop_addr", imem_addr, 32'h10);
        repeat (2) @(negedge clk);
        chk("t2_hold_req", imem_req, 1);
        chk("t2_hold_addr", imem_addr, 32'h10);
        push_exp(32'h10, 32'h14, 32'hC0DE_0010);
        acks_left = 1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (count == 3'd4) begin ok = 1'b1; break; end
        end
        chk("t2_refill", ok, 1);
        chk("t2_refill_req", imem_req, 0);
        out_ready = 1'b1;
        wait_q_empty("t2_drain");

        // redirect while a request is outstanding; its late ack is dropped
        do_reset();
        push_exp(32'h0, 32'h4, 32'hC0DE_0000);
        push_exp(32'h4, 32'h8, 32'hC0DE_0004);
        acks_left = 2; out_ready = 1'b1; reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) begin ok = 1'b1; break; end
        end
        chk("t3_reach_8", ok, 1);
        mem_en = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t3_held_req", imem_req, 1);
        chk("t3_held_addr", imem_addr, 32'h8);
        chk("t3_flush_count", count, 0);
        repeat (2) @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        chk("t3_drop_count", count, 0);
        chk("t3_drop_valid", out_valid, 0);
        chk("t3_new_req", imem_req, 1);
        chk("t3_new_addr", imem_addr, 32'h100);
        push_exp(32'h100, 32'h104, 32'hC0DE_0100);
        mem_en = 1'b1; acks_left = 1;
        wait_q_empty("t3_drain");

        // redirect in the same cycle as an ack
        do_reset();
        push_exp(32'h0, 32'h4, 32'hC0DE_0000);
        acks_left = 1; out_ready = 1'b1; reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h4) begin ok = 1'b1; break; end
        end
        chk("t4_reach_4", ok, 1);
        mem_en = 1'b0;
        @(negedge clk);
        man_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        man_ack = 1'b0; redirect_valid = 1'b0;
        chk("t4_req_low", imem_req, 0);
        chk("t4_count", count, 0);
        chk("t4_valid", out_valid, 0);
        @(negedge clk);
        chk("t4_new_req", imem_req, 1);
        chk("t4_new_addr", imem_addr, 32'h200);
        push_exp(32'h200, 32'h204, 32'hC0DE_0200);
        mem_en = 1'b1; acks_left = 1;
        wait_q_empty("t4_drain");

        // reset mid-transaction, with a late ack afterwards
        do_reset();
        acks_left = 2; reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count == 3'd2 && imem_req && imem_addr == 32'h8) begin ok = 1'b1; break; end
        end
        chk("t6_setup", ok, 1);
        mem_en = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_req", imem_req, 0);
        man_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        man_ack = 1'b0;
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_count", count, 0);
        chk("t6_valid", out_valid, 0);
        push_exp(32'h0, 32'h4, 32'hC0DE_0000);
        mem_en = 1'b1; acks_left = 1; out_ready = 1'b1;
        wait_q_empty("t6_drain");

        repeat (4) @(negedge clk);
        chk("q_left", q.size(), 0);
        chk("wrap_q_left", q2.size(), 0);
        chk("wrap_acks", acks2, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
